lcd_ctrl_param: RTL and testbench
=================================

# lcd_ctrl_param

Parametrised image display controller, the successor to the fixed 6x6 / 3x3 LCD controller. It loads an IMG_W x IMG_H image over a byte stream into internal storage. After every command it emits a WIN_W x WIN_H display window in raster order. It sits between the image source / command sequencer and the LCD driver, and can optionally mirror the window horizontally or vertically.

## Interface
- DATA_W, 8, pixel width in bits
- IMG_W, 6, image width in pixels
- IMG_H, 6, image height in pixels
- WIN_W, 3, window width in pixels (1 ≤ WIN_W ≤ IMG_W)
- WIN_H, 3, window height in pixels (1 ≤ WIN_H ≤ IMG_H)

Ports:
- clk  input  1  single clock, rising-edge
- reset  input  1  asynchronous, active-high reset
- datain  input  DATA_W  image pixel during load
- cmd  input  3  command code
- cmd_valid  input  1  cmd qualifier
- dataout  output  DATA_W  window pixel
- output_valid  output  1  dataout qualifier
- busy  output  1  high while a command is executing; commands are ignored while high

## Operation
- Command codes:
  - 0 reflash
  - 1 load
  - 2 shift right
  - 3 shift left
  - 4 shift up
  - 5 shift down
  - 6 mirror-X toggle
  - 7 mirror-Y toggle
- Window origin (ox, oy) is the top-left pixel of the window. Default origin is ((IMG_W-WIN_W)/2, (IMG_H-WIN_H)/2), using integer division.
- Origin ranges: ox in 0..IMG_W-WIN_W, oy in 0..IMG_H-WIN_H.
- Shifts move the origin by 1 and clamp at the edges. A clamped shift leaves the origin unchanged but still outputs the window.
- Load: stores IMG_W*IMG_H pixels in raster order (index = y*IMG_W+x). Restores the default origin and clears both mirror flags.
- Every command, including a clamped shift and a mirror toggle, ends with emission of WIN_W*WIN_H pixels.
- Output order: rows top to bottom, columns left to right.
  - Mirror-X reverses the column order within each row.
  - Mirror-Y reverses the row order.
- FSM states:
  - IDLE → on cmd_valid & !busy: LOAD (cmd 1) or EXEC (all other commands)
  - LOAD → after M = IMG_W*IMG_H samples: OUT
  - EXEC → OUT after 1 cycle; the origin and flag update happens here
  - OUT → after N = WIN_W*WIN_H pixels: IDLE
- Counter, address and origin widths are derived with $clog2 of the relevant ranges. Pixel address = (oy+r)*IMG_W + (ox+c), computed without overflow for all legal parameters.
- Reset values:
  - dataout = 0, output_valid = 0, busy = 0
  - origin = default, mirror flags = 0, state = IDLE
  - image memory is not cleared; its contents are undefined until the first load
- Reset mid-load or mid-output aborts immediately; the next accepted command starts clean.
- Reflash or shift issued before any load outputs undefined pixel values but follows the normal handshake.

## Timing
- Command accepted at rising edge k (cmd_valid=1, busy=0). busy=1 from edge k.
- Non-load commands:
  - the origin/flag update takes effect at edge k+1
  - output_valid=1 with pixels 0..N-1 after edges k+2 .. k+N+1
  - output_valid=0 and busy=0 after edge k+N+2
- Load:
  - datain is sampled at edges k+1 .. k+M
  - output pixels follow after edges k+M+2 .. k+M+N+1
  - busy falls after edge k+M+2+N
- The earliest next command is accepted at the first edge where busy=0 is sampled.
- cmd_valid while busy=1 is ignored, with no queuing.
- dataout holds its last value when output_valid=0.

## Configuration
- LCD_MIRROR_EN defined: cmds 6/7 toggle mirror-X/mirror-Y, and output order honours both flags.
- LCD_MIRROR_EN undefined: no mirror flags exist. Cmds 6/7 behave exactly as reflash (cmd 0), and output order is always plain raster.

## Test plan
All scenarios use default parameters and an image with pixel i = i (hex 00..23).
- Load, then reflash → two bursts, each 07 08 09 0D 0E 0F 13 14 15. busy low between bursts.
- Load, then 4× shift right → bursts at ox=2, ox=3, ox=3, ox=3; the last burst is 09 0A 0B 0F 10 11 15 16 17. Clamp verified.
- Load, then 2× shift up, 1× shift left → oy clamps at 0; the final burst is 00 01 02 06 07 08 0C 0D 0E.
- With LCD_MIRROR_EN: load, cmd 6 → 09 08 07 0F 0E 0D 15 14 13. Then cmd 7 → 15 14 13 0F 0E 0D 09 08 07. Then load → mirrors cleared, 07 08 09 0D 0E 0F 13 14 15.
- Without LCD_MIRROR_EN: load, cmd 6 → 07 08 09 0D 0E 0F 13 14 15.
- Assert reset during the 5th output pixel → all outputs 0 immediately. Then a reflash without reload outputs the default window of the retained image, 07 08 09 0D 0E 0F 13 14 15. Also pulse cmd_valid while busy=1 and confirm it has no effect.

Source files
------------

// File: rtl/lcd_ctrl_param.sv
// lcd_ctrl_param: loads an IMG_W x IMG_H image and streams a WIN_W x WIN_H window after every command; `define LCD_MIRROR_EN enables mirror commands 6/7
module lcd_ctrl_param #(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 6,
   parameter int IMG_H  = 6,
   parameter int WIN_W  = 3,
   parameter int WIN_H  = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] datain,
   input  logic [2:0]        cmd,
   input  logic              cmd_valid,
   output logic [DATA_W-1:0] dataout,
   output logic              output_valid,
   output logic              busy
);
   localparam int M  = IMG_W * IMG_H;
   localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int AW = (M > 1) ? $clog2(M) : 1;
   localparam int LW = $clog2(M + 1);
   localparam logic [XW-1:0] OX_MAX = XW'(IMG_W - WIN_W);
   localparam logic [YW-1:0] OY_MAX = YW'(IMG_H - WIN_H);
   localparam logic [XW-1:0] OX_DEF = XW'((IMG_W - WIN_W) / 2);
   localparam logic [YW-1:0] OY_DEF = YW'((IMG_H - WIN_H) / 2);
   localparam logic [XW-1:0] C_LAST = XW'(WIN_W - 1);
   localparam logic [YW-1:0] R_LAST = YW'(WIN_H - 1);
   localparam logic [LW-1:0] L_END  = LW'(M);

   typedef enum logic [1:0] {IDLE, LOAD, EXEC, OUT} state_t;

   state_t            state_q, state_d;
   logic [2:0]        cmd_q, cmd_d;
   logic [XW-1:0]     ox_q, ox_d, c_q, c_d, sc;
   logic [YW-1:0]     oy_q, oy_d, r_q, r_d, sr;
   logic [LW-1:0]     lc_q, lc_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              vld_q, vld_d, we;
   logic [AW-1:0]     addr;
   logic [DATA_W-1:0] mem [M];

`ifdef LCD_MIRROR_EN
   logic mx_q, mx_d, my_q, my_d;
   assign sc = mx_q ? C_LAST - c_q : c_q;
   assign sr = my_q ? R_LAST - r_q : r_q;
`else
   assign sc = c_q;
   assign sr = r_q;
`endif

   // Row/column sums stay below IMG_H/IMG_W, so the AW-wide product never wraps
   assign addr         = AW'(oy_q + sr) * AW'(IMG_W) + AW'(ox_q + sc);
   assign dataout      = dout_q;
   assign output_valid = vld_q;
   // The last pixel leaves with the FSM already in IDLE; keep busy until it is gone
   assign busy         = (state_q != IDLE) | vld_q;

   // Image store: written only while loading, deliberately not reset
   always_ff @(posedge clk)
      if (we) mem[lc_q[AW-1:0]] <= datain;

   // Control and datapath registers
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= IDLE;
         cmd_q   <= '0;
         ox_q    <= OX_DEF;
         oy_q    <= OY_DEF;
         c_q     <= '0;
         r_q     <= '0;
         lc_q    <= '0;
         dout_q  <= '0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         ox_q    <= ox_d;
         oy_q    <= oy_d;
         c_q     <= c_d;
         r_q     <= r_d;
         lc_q    <= lc_d;
         dout_q  <= dout_d;
         vld_q   <= vld_d;
      end

`ifdef LCD_MIRROR_EN
   // Mirror flags
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         mx_q <= 1'b0;
         my_q <= 1'b0;
      end else begin
         mx_q <= mx_d;
         my_q <= my_d;
      end
`endif

   // Command decode, load sequencing, origin/flag update and window readout
   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      ox_d    = ox_q;
      oy_d    = oy_q;
      c_d     = c_q;
      r_d     = r_q;
      lc_d    = lc_q;
      dout_d  = dout_q;
      vld_d   = 1'b0;
      we      = 1'b0;
`ifdef LCD_MIRROR_EN
      mx_d    = mx_q;
      my_d    = my_q;
`endif
      case (state_q)
         IDLE:
            if (cmd_valid && !vld_q) begin
               cmd_d   = cmd;
               lc_d    = '0;
               state_d = (cmd == 3'd1) ? LOAD : EXEC;
            end
         LOAD:
            if (lc_q == L_END) begin
               state_d = OUT;
               ox_d    = OX_DEF;
               oy_d    = OY_DEF;
               c_d     = '0;
               r_d     = '0;
`ifdef LCD_MIRROR_EN
               mx_d    = 1'b0;
               my_d    = 1'b0;
`endif
            end else begin
               we   = 1'b1;
               lc_d = lc_q + 1'b1;
            end
         EXEC: begin
            state_d = OUT;
            c_d     = '0;
            r_d     = '0;
            case (cmd_q)
               3'd2: ox_d = (ox_q < OX_MAX) ? ox_q + 1'b1 : ox_q;
               3'd3: ox_d = (ox_q != '0) ? ox_q - 1'b1 : ox_q;
               3'd4: oy_d = (oy_q != '0) ? oy_q - 1'b1 : oy_q;
               3'd5: oy_d = (oy_q < OY_MAX) ? oy_q + 1'b1 : oy_q;
`ifdef LCD_MIRROR_EN
               3'd6: mx_d = ~mx_q;
               3'd7: my_d = ~my_q;
`endif
               default: ;
            endcase
         end
         OUT: begin
            dout_d = mem[addr];
            vld_d  = 1'b1;
            c_d    = (c_q == C_LAST) ? '0 : c_q + 1'b1;
            r_d    = (c_q == C_LAST) ? r_q + 1'b1 : r_q;
            if (c_q == C_LAST && r_q == R_LAST) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_lcd_ctrl_param.sv
// tb_lcd_ctrl_param: directed bench with a window-level scoreboard model and literal burst checks
module tb_lcd_ctrl_param;
   localparam int IW = 6, IH = 6, WW = 3, WH = 3, M = IW * IH, N = WW * WH;

   logic       clk = 1'b0, reset = 1'b0, cmd_valid = 1'b0;
   logic [7:0] datain = 8'h00;
   logic [2:0] cmd = 3'd0;
   logic [7:0] dataout;
   logic       output_valid, busy;

   always #5 clk = ~clk;

   lcd_ctrl_param #(.DATA_W(8), .IMG_W(IW), .IMG_H(IH), .WIN_W(WW), .WIN_H(WH)) dut (
      .clk(clk), .reset(reset), .datain(datain), .cmd(cmd), .cmd_valid(cmd_valid),
      .dataout(dataout), .output_valid(output_valid), .busy(busy));

   typedef struct {bit v; logic [7:0] d;} exp_t;

   exp_t       sched[$];
   logic [7:0] got[$];
   logic [7:0] img[M];
   logic [7:0] last = 8'h00;
   int         ox = 1, oy = 1;
   bit         mx = 0, my = 0;
   int         n_cmp = 0, n_bad = 0;

   function automatic void push_burst();
      exp_t e;
      for (int r = 0; r < WH; r++)
         for (int c = 0; c < WW; c++) begin
            int sr = my ? WH - 1 - r : r;
            int sc = mx ? WW - 1 - c : c;
            e.v = 1'b1;
            e.d = img[(oy + sr) * IW + ox + sc];
            sched.push_back(e);
         end
   endfunction

   // Scoreboard: one expected entry per cycle while busy; idle otherwise
   always @(negedge clk) begin
      exp_t e;
      bit   eb;
      if (reset) begin
         n_cmp++;
         if (dataout !== 8'h00 || output_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got d=%h v=%b b=%b, required 00/0/0", dataout, output_valid, busy);
         end
         last = 8'h00;
      end else begin
         if (sched.size() != 0) begin
            e  = sched.pop_front();
            eb = 1'b1;
         end else begin
            e.v = 1'b0;
            e.d = 8'h00;
            eb  = 1'b0;
         end
         if (e.v) last = e.d;
         n_cmp++;
         if (busy !== eb || output_valid !== e.v || dataout !== last) begin
            n_bad++;
            $display("FAIL cycle t=%0t: got d=%h v=%b b=%b, required d=%h v=%b b=%b",
                     $time, dataout, output_valid, busy, last, e.v, eb);
         end
         if (output_valid === 1'b1) got.push_back(dataout);
      end
   end

   task automatic wait_idle();
      int t = 0;
      while (sched.size() != 0 && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (sched.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL idle_timeout: got %0d pending, required 0", sched.size());
         sched.delete();
      end
      @(negedge clk);
   endtask

   task automatic issue(input logic [2:0] c);
      wait_idle();
      got.delete();
      cmd       = c;
      cmd_valid = 1'b1;
      @(posedge clk);
      case (c)
         3'd1: begin ox = (IW - WW) / 2; oy = (IH - WH) / 2; mx = 0; my = 0; end
         3'd2: if (ox < IW - WW) ox++;
         3'd3: if (ox > 0) ox--;
         3'd4: if (oy > 0) oy--;
         3'd5: if (oy < IH - WH) oy++;
`ifdef LCD_MIRROR_EN
         3'd6: mx = !mx;
         3'd7: my = !my;
`endif
         default: ;
      endcase
      begin
         exp_t e;
         e.v = 1'b0;
         e.d = 8'h00;
         repeat ((c == 3'd1) ? M + 2 : 2) sched.push_back(e);
      end
      push_burst();
      #1 cmd_valid = 1'b0;
      if (c == 3'd1) begin
         for (int i = 0; i < M; i++) begin
            datain = img[i];
            @(posedge clk);
            #1;
         end
         datain = 8'hFF;
      end
   endtask

   task automatic check_burst(input string name, input logic [71:0] lit);
      bit    ok;
      string s = "";
      wait_idle();
      n_cmp++;
      ok = (got.size() == N);
      for (int i = 0; i < N; i++)
         if (ok && got[i] !== lit[71-8*i -: 8]) ok = 0;
      if (!ok) begin
         foreach (got[i]) s = {s, $sformatf("%h ", got[i])};
         n_bad++;
         $display("FAIL %s: got %s, required %h", name, s, lit);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < M; i++) img[i] = 8'(i);
      #1 reset = 1'b1;
      #20 reset = 1'b0;

      issue(3'd1);
      check_burst("load_default", 72'h07_08_09_0D_0E_0F_13_14_15);
      issue(3'd0);
      check_burst("reflash", 72'h07_08_09_0D_0E_0F_13_14_15);

      issue(3'd2);
      check_burst("shift_right_1", 72'h08_09_0A_0E_0F_10_14_15_16);
      repeat (3) issue(3'd2);
      check_burst("shift_right_clamp", 72'h09_0A_0B_0F_10_11_15_16_17);

      issue(3'd1);
      issue(3'd4);
      issue(3'd4);
      issue(3'd3);
      check_burst("up_clamp_left", 72'h00_01_02_06_07_08_0C_0D_0E);

      issue(3'd1);
      issue(3'd6);
`ifdef LCD_MIRROR_EN
      check_burst("mirror_x", 72'h09_08_07_0F_0E_0D_15_14_13);
      issue(3'd7);
      check_burst("mirror_xy", 72'h15_14_13_0F_0E_0D_09_08_07);
      issue(3'd1);
      check_burst("load_clears_mirror", 72'h07_08_09_0D_0E_0F_13_14_15);
`else
      check_burst("cmd6_as_reflash", 72'h07_08_09_0D_0E_0F_13_14_15);
      issue(3'd7);
      check_burst("cmd7_as_reflash", 72'h07_08_09_0D_0E_0F_13_14_15);
`endif

      repeat (3) issue(3'd5);
      check_burst("shift_down_clamp", 72'h13_14_15_19_1A_1B_1F_20_21);

      issue(3'd0);
      cmd       = 3'd2;
      cmd_valid = 1'b1;
      repeat (N + 2) @(posedge clk);
      #1 cmd_valid = 1'b0;
      check_burst("busy_cmd_ignored", 72'h13_14_15_19_1A_1B_1F_20_21);
      issue(3'd0);
      check_burst("origin_unchanged", 72'h13_14_15_19_1A_1B_1F_20_21);

      issue(3'd0);
      repeat (6) @(posedge clk);
      #2 reset = 1'b1;
      sched.delete();
      ox = 1; oy = 1; mx = 0; my = 0;
      #1;
      n_cmp++;
      if (dataout !== 8'h00 || output_valid !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_immediate: got d=%h v=%b b=%b, required 00/0/0", dataout, output_valid, busy);
      end
      n_cmp++;
      if (got.size() != 4) begin
         n_bad++;
         $display("FAIL pixels_before_reset: got %0d, required 4", got.size());
      end
      @(negedge clk);
      #1 reset = 1'b0;
      issue(3'd0);
      check_burst("reflash_after_reset", 72'h07_08_09_0D_0E_0F_13_14_15);

      wait_idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
